// File: rtl/mips_pkg.sv
// Shared widths and constants for the MIPS pipeline register file and its trace.
package mips_pkg;
  localparam int          REG_ADDR_W = 5;
  localparam int          NUM_REGS   = 32;
  localparam int          DATA_W     = 32;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [4:0]  ZERO_REG   = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;
endpackage

// File: rtl/grf_trace.sv
// Registered write-trace record and commit counter, updated on every commit edge.
module grf_trace
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      commit,
  input  data_t     pc4,
  input  reg_addr_t addr,
  input  data_t     data,
  output logic      trace_valid,
  output data_t     trace_pc,
  output reg_addr_t trace_addr,
  output data_t     trace_data,
  output data_t     write_count
);

  logic      valid_q, valid_d;
  data_t     pc_q, pc_d;
  reg_addr_t addr_q, addr_d;
  data_t     data_q, data_d;
  data_t     count_q, count_d;

  // Fields other than the valid pulse hold their last committed record.
  always_comb begin
    valid_d = 1'b0;
    pc_d    = pc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    if (commit) begin
      valid_d = 1'b1;
      pc_d    = pc4 - PC_STEP;
      addr_d  = addr;
      data_d  = data;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign trace_valid = valid_q;
  assign trace_pc    = pc_q;
  assign trace_addr  = addr_q;
  assign trace_data  = data_q;
  assign write_count = count_q;

endmodule

// File: rtl/grf.sv
// Two-read/one-write register file with same-cycle write bypass and commit trace.
module grf
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      RegWrite_W,
  input  reg_addr_t A3_W,
  input  data_t     WD_W,
  input  data_t     PC4_W,
  input  reg_addr_t A1,
  input  reg_addr_t A2,
  output data_t     RD1,
  output data_t     RD2,
  output logic      trace_valid,
  output data_t     trace_pc,
  output reg_addr_t trace_addr,
  output data_t     trace_data,
  output data_t     write_count
);

  logic  commit;
  data_t regs_q [NUM_REGS];
  data_t regs_d [NUM_REGS];

  // Writes to $0 are dropped everywhere: storage, bypass, trace and count.
  assign commit = RegWrite_W && (A3_W != ZERO_REG);

  always_comb begin
    regs_d = regs_q;
    if (commit) regs_d[A3_W] = WD_W;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass uses the live writeback inputs, so it also works while reset is low.
  assign RD1 = (A1 == ZERO_REG) ? '0 :
               (commit && (A3_W == A1)) ? WD_W : regs_q[A1];
  assign RD2 = (A2 == ZERO_REG) ? '0 :
               (commit && (A3_W == A2)) ? WD_W : regs_q[A2];

  grf_trace u_trace (
    .clk         (clk),
    .reset       (reset),
    .commit      (commit),
    .pc4         (PC4_W),
    .addr        (A3_W),
    .data        (WD_W),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .write_count (write_count)
  );

endmodule
